// File: rtl/action_axilite_ctrl_regs.sv
// AXI-Lite control/status register file between the MMIO bridge and an action kernel.
// Define ACTION_CYCLE_COUNTER_EN to build the CYCLES run-time counter at offset 0x30.
module action_axilite_ctrl_regs #(
  parameter int unsigned NUM_ARGS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            s_axi_awaddr,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [31:0]            s_axi_wdata,
  input  logic [3:0]             s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [31:0]            s_axi_araddr,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [31:0]            s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic                   ap_start,
  input  logic                   ap_done,
  input  logic                   ap_idle,
  input  logic                   ap_ready,
  output logic [32*NUM_ARGS-1:0] ap_args,
  output logic                   interrupt
);

  localparam logic [4:0] IdxCtrl   = 5'd0;
  localparam logic [4:0] IdxGie    = 5'd1;
  localparam logic [4:0] IdxIer    = 5'd2;
  localparam logic [4:0] IdxIsr    = 5'd3;
  localparam logic [4:0] IdxCycles = 5'd12;
  localparam int unsigned ArgBase  = 4;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  logic                       rdy_en_q;
  logic                       aw_q, w_q, wr_pend_q, bvalid_q;
  logic [4:0]                 aw_idx_q;
  logic [31:0]                wdata_q;
  logic [3:0]                 wstrb_q;
  logic [1:0]                 bresp_q;
  logic                       rd_pend_q, rvalid_q;
  logic [31:0]                rdata_q;
  logic [1:0]                 rresp_q;
  logic                       ap_start_q, ap_start_d, done_q, done_d, auto_q, auto_d;
  logic                       gie_q, gie_d, ier_q, ier_d, isr_q, isr_d, irq_q;
  logic [NUM_ARGS-1:0][31:0]  args_q, args_d;
  logic                       aw_hs, w_hs, ar_hs, wr_fire;
  logic [4:0]                 wr_idx, rd_idx;
  logic [31:0]                wr_data, rd_data, cycles;
  logic [3:0]                 wr_strb;
  logic [1:0]                 rd_resp;
  logic                       unused_addr_bits;

  assign unused_addr_bits = ^{s_axi_awaddr[31:7], s_axi_awaddr[1:0],
                              s_axi_araddr[31:7], s_axi_araddr[1:0]};

  function automatic logic [1:0] decode_resp(logic [4:0] idx);
    logic mapped;
    mapped = (idx <= IdxIsr) || (idx == IdxCycles);
    for (int unsigned i = 0; i < NUM_ARGS; i++) begin
      if (idx == 5'(ArgBase + i)) mapped = 1'b1;
    end
    return mapped ? RespOkay : RespSlvErr;
  endfunction

  // Readies stay low until the first edge after reset release.
  assign s_axi_awready = rdy_en_q & ~aw_q & ~wr_pend_q & ~bvalid_q;
  assign s_axi_wready  = rdy_en_q & ~w_q & ~wr_pend_q & ~bvalid_q;
  assign s_axi_arready = rdy_en_q & ~rd_pend_q & ~rvalid_q;

  assign aw_hs   = s_axi_awvalid & s_axi_awready;
  assign w_hs    = s_axi_wvalid & s_axi_wready;
  assign ar_hs   = s_axi_arvalid & s_axi_arready;
  // A write commits on the edge where the second of AW/W arrives.
  assign wr_fire = (aw_q | aw_hs) & (w_q | w_hs);
  assign wr_idx  = aw_q ? aw_idx_q : s_axi_awaddr[6:2];
  assign wr_data = w_q ? wdata_q : s_axi_wdata;
  assign wr_strb = w_q ? wstrb_q : s_axi_wstrb;
  assign rd_idx  = s_axi_araddr[6:2];

  always_comb begin
    ap_start_d = ap_start_q;
    done_d     = done_q;
    auto_d     = auto_q;
    gie_d      = gie_q;
    ier_d      = ier_q;
    isr_d      = isr_q;
    args_d     = args_q;
    if (ap_ready && !auto_q) ap_start_d = 1'b0;
    if (ar_hs && rd_idx == IdxCtrl) done_d = 1'b0;
    if (wr_fire) begin
      case (wr_idx)
        IdxCtrl: begin
          if (wr_data[0]) ap_start_d = 1'b1;
          auto_d = wr_data[7];
        end
        IdxGie:  gie_d = wr_data[0];
        IdxIer:  ier_d = wr_data[0];
        IdxIsr:  if (wr_data[0]) isr_d = 1'b0;
        default: begin
          for (int unsigned i = 0; i < NUM_ARGS; i++) begin
            if (wr_idx == 5'(ArgBase + i)) begin
              for (int unsigned b = 0; b < 4; b++) begin
                if (wr_strb[b]) args_d[i][8*b +: 8] = wr_data[8*b +: 8];
              end
            end
          end
        end
      endcase
    end
    // Completion events take priority over same-cycle clears.
    if (ap_done) done_d = 1'b1;
    if (ap_done && ier_q) isr_d = 1'b1;
  end

  always_comb begin
    rd_data = '0;
    rd_resp = decode_resp(rd_idx);
    case (rd_idx)
      IdxCtrl:   rd_data = {24'd0, auto_q, 3'd0, ap_ready, ap_idle, done_q, ap_start_q};
      IdxGie:    rd_data = {31'd0, gie_q};
      IdxIer:    rd_data = {31'd0, ier_q};
      IdxIsr:    rd_data = {31'd0, isr_q};
      IdxCycles: rd_data = cycles;
      default: begin
        for (int unsigned i = 0; i < NUM_ARGS; i++) begin
          if (rd_idx == 5'(ArgBase + i)) rd_data = args_q[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_en_q   <= 1'b0;
      aw_q       <= 1'b0;
      aw_idx_q   <= '0;
      w_q        <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pend_q  <= 1'b0;
      bresp_q    <= '0;
      bvalid_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rvalid_q   <= 1'b0;
      ap_start_q <= 1'b0;
      done_q     <= 1'b0;
      auto_q     <= 1'b0;
      gie_q      <= 1'b0;
      ier_q      <= 1'b0;
      isr_q      <= 1'b0;
      irq_q      <= 1'b0;
      args_q     <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      if (wr_pend_q) begin
        wr_pend_q <= 1'b0;
        bvalid_q  <= 1'b1;
      end else if (s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (wr_fire) begin
        aw_q      <= 1'b0;
        w_q       <= 1'b0;
        wr_pend_q <= 1'b1;
        bresp_q   <= decode_resp(wr_idx);
      end else begin
        if (aw_hs) begin
          aw_q     <= 1'b1;
          aw_idx_q <= s_axi_awaddr[6:2];
        end
        if (w_hs) begin
          w_q     <= 1'b1;
          wdata_q <= s_axi_wdata;
          wstrb_q <= s_axi_wstrb;
        end
      end
      // Read data is sampled at the AR edge so a same-cycle write is not visible.
      if (rd_pend_q) begin
        rd_pend_q <= 1'b0;
        rvalid_q  <= 1'b1;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rd_pend_q <= 1'b1;
        rdata_q   <= rd_data;
        rresp_q   <= rd_resp;
      end
      ap_start_q <= ap_start_d;
      done_q     <= done_d;
      auto_q     <= auto_d;
      gie_q      <= gie_d;
      ier_q      <= ier_d;
      isr_q      <= isr_d;
      irq_q      <= gie_q & isr_q;
      args_q     <= args_d;
    end
  end

`ifdef ACTION_CYCLE_COUNTER_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_q <= '0;
    end else if (ap_start_d && !ap_start_q) begin
      cycles_q <= '0;
    end else if (!ap_idle && cycles_q != 32'hFFFF_FFFF) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign cycles = cycles_q;
`else
  assign cycles = '0;
`endif

  assign s_axi_bresp  = bresp_q;
  assign s_axi_bvalid = bvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign ap_start     = ap_start_q;
  assign ap_args      = args_q;
  assign interrupt    = irq_q;

endmodule

// File: tb/tb_action_axilite_ctrl_regs.sv
// Self-checking bench for action_axilite_ctrl_regs: vector table, directed corner cases and
// randomized traffic against a transaction-level register model.
module tb_action_axilite_ctrl_regs;

  localparam int unsigned NA = 6;
`ifdef ACTION_CYCLE_COUNTER_EN
  localparam logic [31:0] ExpCycles = 32'd100;
`else
  localparam logic [31:0] ExpCycles = 32'd0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     awaddr = '0, wdata = '0, araddr = '0;
  logic            awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic [3:0]      wstrb = '0;
  logic            bready = 1'b1, rready = 1'b1;
  logic            awready, wready, bvalid, arready, rvalid;
  logic [1:0]      bresp, rresp;
  logic [31:0]     rdata;
  logic            ap_start, interrupt;
  logic            ap_done = 1'b0, ap_idle = 1'b1, ap_ready = 1'b0;
  logic [32*NA-1:0] ap_args;

  always #5 clk = ~clk;

  action_axilite_ctrl_regs #(.NUM_ARGS(NA)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .ap_args(ap_args), .interrupt(interrupt)
  );

  int total = 0;
  int bad = 0;
  int bcount = 0;
  int rcount = 0;

  always @(posedge clk) begin
    if (bvalid && bready) bcount <= bcount + 1;
    if (rvalid && rready) rcount <= rcount + 1;
  end

  // Register model
  logic [31:0] m_args [NA];
  logic        m_start, m_done, m_auto, m_gie, m_ier, m_isr;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) m_args[i] = '0;
    m_start = 0; m_done = 0; m_auto = 0; m_gie = 0; m_ier = 0; m_isr = 0;
  endtask

  task automatic model_done();
    m_done = 1'b1;
    if (m_ier) m_isr = 1'b1;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    int off;
    int k;
    off  = int'(addr[6:2]) * 4;
    resp = 2'b00;
    if (off == 0) begin
      if (data[0]) m_start = 1'b1;
      m_auto = data[7];
    end else if (off == 4) m_gie = data[0];
    else if (off == 8) m_ier = data[0];
    else if (off == 'hC) begin
      if (data[0]) m_isr = 1'b0;
    end else if (off == 'h30) resp = 2'b00;
    else if (off >= 'h10 && off < 'h10 + 4 * NA) begin
      k = (off - 'h10) / 4;
      for (int b = 0; b < 4; b++) if (strb[b]) m_args[k][8*b +: 8] = data[8*b +: 8];
    end else resp = 2'b10;
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
    int off;
    off  = int'(addr[6:2]) * 4;
    data = '0;
    resp = 2'b00;
    if (off == 0) begin
      data = 32'(m_auto) * 128 + 32'(ap_idle) * 4 + 32'(m_done) * 2 + 32'(m_start);
      m_done = 1'b0;
    end else if (off == 4) data = 32'(m_gie);
    else if (off == 8) data = 32'(m_ier);
    else if (off == 'hC) data = 32'(m_isr);
    else if (off == 'h30) data = ExpCycles;
    else if (off >= 'h10 && off < 'h10 + 4 * NA) data = m_args[(off - 'h10) / 4];
    else resp = 2'b10;
  endtask

  task automatic check_state(input string name);
    for (int i = 0; i < NA; i++)
      check($sformatf("%s arg%0d", name, i), ap_args[32*i +: 32], m_args[i]);
    check({name, " ap_start"}, 32'(ap_start), 32'(m_start));
    check({name, " interrupt"}, 32'(interrupt), 32'(m_gie & m_isr));
  endtask

  task automatic axi_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input logic done_p, input logic ready_p, output logic [1:0] resp);
    bit aw_pend, w_pend, aw_hs, w_hs;
    int n;
    @(negedge clk);
    ap_done = done_p;
    ap_ready = ready_p;
    aw_pend = 1; w_pend = 1; n = 0;
    resp = 2'bxx;
    while ((aw_pend || w_pend) && n < 64) begin
      if (aw_pend && n >= aw_dly) begin awvalid = 1; awaddr = addr; end
      if (w_pend && n >= w_dly) begin wvalid = 1; wdata = data; wstrb = strb; end
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk);
      n++;
      ap_done = 0;
      ap_ready = 0;
      if (aw_hs) begin aw_pend = 0; awvalid = 0; end
      if (w_hs) begin w_pend = 0; wvalid = 0; end
    end
    awvalid = 0;
    wvalid = 0;
    if (aw_pend || w_pend) timeout({name, " aw/w"});
    else begin
      n = 0;
      while (!bvalid && n < 16) begin @(negedge clk); n++; end
      if (!bvalid) timeout({name, " b"});
      else resp = bresp;
    end
  endtask

  task automatic axi_read(input string name, input logic [31:0] addr, input logic done_p,
                          output logic [31:0] data, output logic [1:0] resp);
    bit hs;
    int n;
    @(negedge clk);
    arvalid = 1; araddr = addr; ap_done = done_p;
    hs = 0; n = 0;
    data = 'x; resp = 'x;
    while (!hs && n < 64) begin
      hs = arready;
      @(negedge clk);
      n++;
      ap_done = 0;
    end
    arvalid = 0;
    if (!hs) timeout({name, " ar"});
    else begin
      n = 0;
      while (!rvalid && n < 16) begin @(negedge clk); n++; end
      if (!rvalid) timeout({name, " r"});
      else begin data = rdata; resp = rresp; end
    end
  endtask

  task automatic do_write(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input logic done_p, input logic ready_p);
    logic [1:0] resp, mresp;
    if (ready_p && !m_auto) m_start = 1'b0;
    model_write(addr, data, strb, mresp);
    if (done_p) model_done();
    axi_write(name, addr, data, strb, aw_dly, w_dly, done_p, ready_p, resp);
    check({name, " bresp"}, 32'(resp), 32'(mresp));
  endtask

  task automatic do_read(input string name, input logic [31:0] addr, input logic done_p,
                         output logic [31:0] data);
    logic [31:0] mdata;
    logic [1:0]  resp, mresp;
    model_read(addr, mdata, mresp);
    if (done_p) model_done();
    axi_read(name, addr, done_p, data, resp);
    check({name, " rdata"}, data, mdata);
    check({name, " rresp"}, 32'(resp), 32'(mresp));
  endtask

  task automatic pulse(input logic d, input logic r);
    @(negedge clk);
    ap_done = d; ap_ready = r;
    @(negedge clk);
    ap_done = 0; ap_ready = 0;
    @(negedge clk);
    if (r && !m_auto) m_start = 1'b0;
    if (d) model_done();
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl [16];
    logic [31:0] d, r32;
    logic [1:0]  resp, mresp;
    int          b0, r0, op, idx;

    tbl[0]  = '{1'b0, 32'h00, 32'h0, 4'h0, 32'h4, 2'b00};
    tbl[1]  = '{1'b1, 32'h10, 32'h1234_5678, 4'hF, 32'h0, 2'b00};
    tbl[2]  = '{1'b0, 32'h10, 32'h0, 4'h0, 32'h1234_5678, 2'b00};
    tbl[3]  = '{1'b1, 32'h24, 32'hA5A5_A5A5, 4'b1000, 32'h0, 2'b00};
    tbl[4]  = '{1'b0, 32'h24, 32'h0, 4'h0, 32'hA500_0000, 2'b00};
    tbl[5]  = '{1'b1, 32'h28, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b10};
    tbl[6]  = '{1'b0, 32'h28, 32'h0, 4'h0, 32'h0, 2'b10};
    tbl[7]  = '{1'b0, 32'h3C, 32'h0, 4'h0, 32'h0, 2'b10};
    tbl[8]  = '{1'b1, 32'h40, 32'h1, 4'hF, 32'h0, 2'b10};
    tbl[9]  = '{1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 2'b00};
    tbl[10] = '{1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b00};
    tbl[11] = '{1'b0, 32'h04, 32'h0, 4'h0, 32'h1, 2'b00};
    tbl[12] = '{1'b1, 32'h04, 32'h0, 4'hF, 32'h0, 2'b00};
    tbl[13] = '{1'b0, 32'h08, 32'h0, 4'h0, 32'h0, 2'b00};
    tbl[14] = '{1'b0, 32'h0C, 32'h0, 4'h0, 32'h0, 2'b00};
    tbl[15] = '{1'b0, 32'h13, 32'h0, 4'h0, 32'h1234_5678, 2'b00};

    model_reset();
    #3;
    check("rst awready", 32'(awready), 0);
    check("rst arready", 32'(arready), 0);
    check("rst bvalid", 32'(bvalid), 0);
    check("rst rvalid", 32'(rvalid), 0);
    check("rst rdata", rdata, 0);
    check("rst ap_start", 32'(ap_start), 0);
    check("rst interrupt", 32'(interrupt), 0);
    check("rst ap_args", 32'(|ap_args), 0);
    @(negedge clk);
    reset = 0;
    #1;
    check("awready before first edge", 32'(awready), 0);
    @(posedge clk);
    #1;
    check("awready after first edge", 32'(awready), 1);
    check("wready after first edge", 32'(wready), 1);
    check("arready after first edge", 32'(arready), 1);

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) begin
        model_write(tbl[i].addr, tbl[i].data, tbl[i].strb, mresp);
        axi_write($sformatf("vec%0d", i), tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, 0, 0, resp);
        check($sformatf("vec%0d bresp", i), 32'(resp), 32'(tbl[i].exp_resp));
      end else begin
        axi_read($sformatf("vec%0d", i), tbl[i].addr, 0, d, resp);
        check($sformatf("vec%0d rdata", i), d, tbl[i].exp_data);
        check($sformatf("vec%0d rresp", i), 32'(resp), 32'(tbl[i].exp_resp));
      end
    end
    check("arg0 output", ap_args[31:0], 32'h1234_5678);
    check("unmapped write no start", 32'(ap_start), 0);
    check_state("after table");

    // AW leads W by three cycles; exactly one B response.
    b0 = bcount;
    do_write("aw early", 32'h14, 32'hFFFF_FFFF, 4'b0101, 0, 3, 0, 0);
    repeat (4) @(negedge clk);
    check("aw early b count", 32'(bcount - b0), 1);
    do_read("arg1 readback", 32'h14, 0, d);
    check("arg1 strobed", d, 32'h00FF_00FF);

    // Start / ready / done handshake.
    do_write("ctrl start", 32'h00, 32'h1, 4'hF, 0, 0, 0, 0);
    check("start set", 32'(ap_start), 1);
    pulse(0, 1);
    check("start cleared by ready", 32'(ap_start), 0);
    pulse(1, 0);
    do_read("ctrl done", 32'h00, 0, d);
    check("done sticky set", 32'(d[1]), 1);
    do_read("ctrl done again", 32'h00, 0, d);
    check("done sticky cleared", 32'(d[1]), 0);
    do_read("ctrl rd with done", 32'h00, 1, d);
    do_read("ctrl after rd+done", 32'h00, 0, d);
    check("done wins over read clear", 32'(d[1]), 1);

    // Interrupt path.
    do_write("gie", 32'h04, 32'h1, 4'hF, 0, 0, 0, 0);
    do_write("ier", 32'h08, 32'h1, 4'hF, 0, 0, 0, 0);
    pulse(1, 0);
    check("irq after done", 32'(interrupt), 1);
    do_write("isr clear", 32'h0C, 32'h1, 4'hF, 0, 0, 0, 0);
    check("irq cleared", 32'(interrupt), 0);
    pulse(1, 0);
    do_write("isr clear+done", 32'h0C, 32'h1, 4'hF, 0, 0, 1, 0);
    check("irq set wins", 32'(interrupt), 1);
    check_state("after irq");

    // Start set vs ap_ready, and auto restart.
    do_write("start again", 32'h00, 32'h1, 4'hF, 0, 0, 0, 0);
    do_write("start+ready", 32'h00, 32'h1, 4'hF, 0, 0, 0, 1);
    check("start wins over ready", 32'(ap_start), 1);
    pulse(0, 1);
    check("start cleared", 32'(ap_start), 0);
    do_write("auto on", 32'h00, 32'h80, 4'hF, 0, 0, 0, 0);
    do_write("auto start", 32'h00, 32'h81, 4'hF, 0, 0, 0, 0);
    pulse(0, 1);
    check("auto restart keeps start", 32'(ap_start), 1);
    do_write("ctrl zero", 32'h00, 32'h0, 4'hF, 0, 0, 0, 0);
    check("write 0 keeps start", 32'(ap_start), 1);
    pulse(0, 1);
    check("start cleared no auto", 32'(ap_start), 0);

    // Busy-cycle counter.
    do_write("cnt start", 32'h00, 32'h1, 4'hF, 0, 0, 0, 0);
    @(negedge clk);
    ap_idle = 0;
    repeat (100) @(negedge clk);
    ap_idle = 1;
    axi_read("cycles", 32'h30, 0, d, resp);
    check("cycles value", d, ExpCycles);
    check("cycles rresp", 32'(resp), 0);
    pulse(0, 1);
    check_state("after cycles");

    // Randomized traffic against the model.
    for (int it = 0; it < 200; it++) begin
      op  = int'($urandom_range(0, 4));
      idx = int'($urandom_range(0, 19));
      if (idx == 12) idx = 13;
      r32 = $urandom();
      if (op <= 1) begin
        do_write($sformatf("rnd%0d wr", it), {r32[31:7], 5'(idx), r32[1:0]}, $urandom(),
                 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 0, 0);
      end else if (op <= 3) begin
        do_read($sformatf("rnd%0d rd", it), {r32[31:7], 5'(idx), r32[1:0]}, 0, d);
      end else begin
        pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      check_state($sformatf("rnd%0d", it));
    end

    // Reset in the middle of a write and a read.
    @(negedge clk);
    awaddr = 32'h10; awvalid = 1; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1;
    araddr = 32'h10; arvalid = 1;
    @(posedge clk);
    #2;
    b0 = bcount;
    r0 = rcount;
    reset = 1;
    #1;
    check("mid reset bvalid", 32'(bvalid), 0);
    check("mid reset rvalid", 32'(rvalid), 0);
    check("mid reset awready", 32'(awready), 0);
    awvalid = 0; wvalid = 0; arvalid = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (6) @(negedge clk);
    check("dropped b response", 32'(bcount - b0), 0);
    check("dropped r response", 32'(rcount - r0), 0);
    model_reset();
    check_state("after mid reset");
    do_write("post reset wr", 32'h10, 32'h0BAD_F00D, 4'hF, 0, 0, 0, 0);
    do_read("post reset rd", 32'h10, 0, d);
    check_state("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
